// File: rtl/exec_pkg.sv
// Shared constants and encodings for the execute/write-back stage.
package exec_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SHL   = 4'd5,
    OP_SHR   = 4'd6,
    OP_MUL   = 4'd7,
    OP_PASSA = 4'd8,
    OP_CMP   = 4'd9
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    WB   = 2'd3
  } state_t;

endpackage

// File: rtl/exec_mul.sv
// Shift-add multiplier, one multiplier bit per cycle (LSB first), W x W -> 2W.
// prod_o carries the final partial sum combinationally while done_o is high.
module exec_mul
  import exec_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           done_o,
  output logic [2*W-1:0] prod_o
);

  localparam int unsigned CW = $clog2(W);

  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;

  always_comb begin
    acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
    done_o = busy_q && (cnt_q == CW'(W - 1));
    prod_o = acc_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      acc_q    <= '0;
      mcand_q  <= {{W{1'b0}}, a_i};
      mplier_q <= b_i;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute/write-back stage: 2-cycle ALU ops, optional 8-cycle MUL, register file write port.
// Define EXEC_MUL_EN to build the multiplier; otherwise opcode 7 is illegal.
module exec_unit #(
  parameter int unsigned DATA_W = exec_pkg::DATA_W,
  parameter int unsigned ADDR_W = exec_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dest_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              flag_z,
  output logic              flag_c,
  output logic              illegal
);
  import exec_pkg::*;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, b_q;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] dest_q;

  logic              wr_en_q, flag_z_q, flag_c_q, illegal_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              accept, fin;
  logic [DATA_W-1:0] res_d;
  logic [DATA_W:0]   ext_d;
  logic              c_d, write_d, ill_d;

  assign accept = op_valid && op_ready;

`ifdef EXEC_MUL_EN
  logic              mul_done;
  logic [2*DATA_W-1:0] mul_prod;

  exec_mul #(
    .W (DATA_W)
  ) u_mul (
    .clk_i   (clk),
    .rst_i   (reset),
    .start_i (accept && (opcode == OP_MUL)),
    .a_i     (src_a),
    .b_i     (src_b),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    op_ready = (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
`ifdef EXEC_MUL_EN
          if (opcode == OP_MUL) state_d = MUL;
`endif
        end
      end
      EXEC: state_d = WB;
`ifdef EXEC_MUL_EN
      MUL:  if (mul_done) state_d = WB;
`else
      MUL:  state_d = IDLE;
`endif
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result, flags and write decision are resolved on the edge entering WB.
  always_comb begin
    res_d   = '0;
    ext_d   = '0;
    c_d     = 1'b0;
    write_d = 1'b1;
    ill_d   = 1'b0;
    fin     = (state_q == EXEC);
    case (op_q)
      OP_ADD: begin
        ext_d = {1'b0, a_q} + {1'b0, b_q};
        res_d = ext_d[DATA_W-1:0];
        c_d   = ext_d[DATA_W];
      end
      OP_SUB, OP_CMP: begin
        ext_d = {1'b0, a_q} - {1'b0, b_q};
        res_d = ext_d[DATA_W-1:0];
        c_d   = ext_d[DATA_W];
        if (op_q == OP_CMP) write_d = 1'b0;
      end
      OP_AND:   res_d = a_q & b_q;
      OP_OR:    res_d = a_q | b_q;
      OP_XOR:   res_d = a_q ^ b_q;
      OP_SHL: begin
        res_d = {a_q[DATA_W-2:0], 1'b0};
        c_d   = a_q[DATA_W-1];
      end
      OP_SHR: begin
        res_d = {1'b0, a_q[DATA_W-1:1]};
        c_d   = a_q[0];
      end
      OP_PASSA: res_d = a_q;
      default: begin
        write_d = 1'b0;
        ill_d   = 1'b1;
      end
    endcase
`ifdef EXEC_MUL_EN
    if (state_q == MUL) begin
      fin     = mul_done;
      res_d   = mul_prod[DATA_W-1:0];
      c_d     = |mul_prod[2*DATA_W-1:DATA_W];
      write_d = 1'b1;
      ill_d   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      dest_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      wr_en_q   <= 1'b0;
      illegal_q <= 1'b0;
      if (accept) begin
        a_q    <= src_a;
        b_q    <= src_b;
        op_q   <= opcode;
        dest_q <= dest_addr;
      end
      if (fin) begin
        if (ill_d) begin
          illegal_q <= 1'b1;
        end else begin
          flag_z_q <= (res_d == '0);
          flag_c_q <= c_d;
          if (write_d) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= dest_q;
            wr_data_q <= res_d;
          end
        end
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign flag_z  = flag_z_q;
  assign flag_c  = flag_c_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit; MUL vectors are used when EXEC_MUL_EN is defined.
module tb_exec_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] opcode;
  logic [7:0] src_a, src_b;
  logic [3:0] dest_addr;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       flag_z, flag_c, illegal;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  exec_unit #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .opcode    (opcode),
    .src_a     (src_a),
    .src_b     (src_b),
    .dest_addr (dest_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] d);
    int unsigned n = 0;
    while (!op_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_before_accept", 32'(op_ready), 32'd1);
    opcode = op; src_a = a; src_b = b; dest_addr = d; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    // Garbage on the inputs after accept must not leak into the result.
    opcode = 4'h3; src_a = 8'hA5; src_b = 8'h5A; dest_addr = 4'hF;
  endtask

  task automatic observe(output int wr_cyc, output int ill_cyc, output int busy,
                         output logic [3:0] addr, output logic [7:0] data);
    wr_cyc = 0; ill_cyc = 0; busy = 0; addr = '0; data = '0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (op_ready) break;
      busy++;
      if (wr_en) begin
        wr_cyc = (wr_cyc == 0) ? cyc : 99;
        addr = wr_addr;
        data = wr_data;
      end
      if (illegal) ill_cyc = (ill_cyc == 0) ? cyc : 99;
      @(posedge clk); #1;
    end
  endtask

  task automatic exp_op(input string name, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [3:0] d, input int exp_wcyc,
                        input logic [7:0] exp_data, input logic exp_z, input logic exp_c,
                        input int exp_busy);
    int wc, ic, bz;
    logic [3:0] ad;
    logic [7:0] dt;
    accept(op, a, b, d);
    observe(wc, ic, bz, ad, dt);
    chk($sformatf("%s_wr_cycle", name), 32'(wc), 32'(exp_wcyc));
    if (exp_wcyc != 0) begin
      chk($sformatf("%s_wr_addr", name), 32'(ad), 32'(d));
      chk($sformatf("%s_wr_data", name), 32'(dt), 32'(exp_data));
    end
    chk($sformatf("%s_illegal", name), 32'(ic), 32'd0);
    chk($sformatf("%s_busy", name), 32'(bz), 32'(exp_busy));
    chk($sformatf("%s_flag_z", name), 32'(flag_z), 32'(exp_z));
    chk($sformatf("%s_flag_c", name), 32'(flag_c), 32'(exp_c));
  endtask

  task automatic exp_illegal(input string name, input logic [3:0] op,
                             input logic exp_z, input logic exp_c, input logic [7:0] keep_data);
    int wc, ic, bz;
    logic [3:0] ad;
    logic [7:0] dt;
    accept(op, 8'h03, 8'h04, 4'h9);
    observe(wc, ic, bz, ad, dt);
    chk($sformatf("%s_ill_cycle", name), 32'(ic), 32'd2);
    chk($sformatf("%s_no_write", name), 32'(wc), 32'd0);
    chk($sformatf("%s_busy", name), 32'(bz), 32'd2);
    chk($sformatf("%s_flag_z", name), 32'(flag_z), 32'(exp_z));
    chk($sformatf("%s_flag_c", name), 32'(flag_c), 32'(exp_c));
    chk($sformatf("%s_wr_data_hold", name), 32'(wr_data), 32'(keep_data));
  endtask

  task automatic check_cleared(input string name);
    chk($sformatf("%s_ready", name), 32'(op_ready), 32'd1);
    chk($sformatf("%s_outs", name),
        32'({wr_en, wr_addr, wr_data, flag_z, flag_c, illegal}), 32'd0);
  endtask

  initial begin
    int pulses;
    reset = 1'b1; op_valid = 1'b0; opcode = '0; src_a = '0; src_b = '0; dest_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    exp_op("add",    4'd0, 8'hF0, 8'h20, 4'd3, 2, 8'h10, 1'b0, 1'b1, 2);
    exp_op("sub_eq", 4'd1, 8'h05, 8'h05, 4'd1, 2, 8'h00, 1'b1, 1'b0, 2);
    exp_op("sub_bw", 4'd1, 8'h03, 8'h04, 4'd2, 2, 8'hFF, 1'b0, 1'b1, 2);
    exp_op("cmp",    4'd9, 8'h10, 8'h10, 4'd5, 0, 8'h00, 1'b1, 1'b0, 2);
    chk("cmp_wr_data_hold", 32'(wr_data), 32'hFF);
    chk("cmp_wr_addr_hold", 32'(wr_addr), 32'd2);
    exp_op("and",    4'd2, 8'hCC, 8'hAA, 4'd6, 2, 8'h88, 1'b0, 1'b0, 2);
    exp_op("or",     4'd3, 8'h0F, 8'hF0, 4'd7, 2, 8'hFF, 1'b0, 1'b0, 2);
    exp_op("xor",    4'd4, 8'h5A, 8'h5A, 4'd8, 2, 8'h00, 1'b1, 1'b0, 2);
    exp_op("shl",    4'd5, 8'h81, 8'h00, 4'd9, 2, 8'h02, 1'b0, 1'b1, 2);
    exp_op("passa",  4'd8, 8'h37, 8'hFF, 4'd10, 2, 8'h37, 1'b0, 1'b0, 2);
    exp_op("shr",    4'd6, 8'h81, 8'h00, 4'd11, 2, 8'h40, 1'b0, 1'b1, 2);
    exp_illegal("op12", 4'd12, 1'b0, 1'b1, 8'h40);

`ifdef EXEC_MUL_EN
    exp_op("mul_a", 4'd7, 8'h0C, 8'h0B, 4'd4, 9, 8'h84, 1'b0, 1'b0, 9);
    exp_op("mul_b", 4'd7, 8'h20, 8'h10, 4'd5, 9, 8'h00, 1'b1, 1'b1, 9);
    accept(4'd7, 8'h33, 8'h02, 4'd6);
    repeat (3) @(posedge clk);
    #1;
`else
    exp_illegal("op7", 4'd7, 1'b0, 1'b1, 8'h40);
    accept(4'd0, 8'h33, 8'h02, 4'd6);
`endif
    #2 reset = 1'b1;
    #1 check_cleared("abort");
    @(posedge clk); #1;
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (wr_en) pulses++;
      @(posedge clk); #1;
    end
    chk("abort_no_write", 32'(pulses), 32'd0);
    exp_op("add_after", 4'd0, 8'h01, 8'h02, 4'd7, 2, 8'h03, 1'b0, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
